iob_cache_mp_arbiter: RTL and testbench
=======================================

Name: iob_cache_mp_arbiter

Overview:
- Multi-port front end for iob_cache. It lets N_PORTS native-interface masters (e.g. CPU instruction port, data port, DMA) share one iob_cache front-end port.
- Generalises the single-master cache front end in channel count.
- Two arbitration modes: round-robin and fixed priority. A starvation guard applies in fixed mode.
- Sits between the masters and iob_cache's valid/addr/wdata/wstrb/rdata/ready port. The controller-select address MSB passes through unchanged.

Parameters:
- N_PORTS, 2: number of master ports (1..8).
- FE_ADDR_W, 32: byte address width, excluding the controller-select bit.
- FE_DATA_W, 32: data word width (multiple of 8).
- CTRL_CACHE, 0: 1 adds the controller-select MSB to each address.
- ARB_MODE, 0: 0 = round-robin; 1 = fixed priority, lowest index wins.
- STARVE_MAX, 15: fixed mode only. Number of lost arbitrations after which a waiting port is forced next (4-bit counter per port).
- FE_NBYTES, FE_DATA_W/8: derived, do not override.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m_valid  in  N_PORTS  per-port request.
- m_addr  in  N_PORTS*(CTRL_CACHE+FE_ADDR_W)  packed per-port address; port i occupies slice i.
- m_wdata  in  N_PORTS*FE_DATA_W  packed write data.
- m_wstrb  in  N_PORTS*FE_NBYTES  packed byte strobes; all zero means read.
- m_rdata  out  FE_DATA_W  read data, broadcast to all ports.
- m_ready  out  N_PORTS  one-hot completion pulse.
- c_valid  out  1  request to iob_cache.
- c_addr  out  CTRL_CACHE+FE_ADDR_W  to iob_cache addr.
- c_wdata  out  FE_DATA_W  to iob_cache wdata.
- c_wstrb  out  FE_NBYTES  to iob_cache wstrb.
- c_rdata  in  FE_DATA_W  from iob_cache rdata.
- c_ready  in  1  from iob_cache ready.
- grant_idx  out  max(1,$clog2(N_PORTS))  index of the currently granted port (debug/counters).

Behaviour:
- Reset values:
  - c_valid=0, m_ready=0, grant_idx=0.
  - c_addr, c_wdata, c_wstrb = 0 (outputs zero when not BUSY).
  - rr pointer=0, starvation counters=0, state IDLE.
- State machine, two states:
  - IDLE: if any m_valid is set, arbitrate, register grant_idx, go to BUSY. Otherwise stay in IDLE.
  - BUSY:
    - c_valid=1.
    - c_addr/c_wdata/c_wstrb are combinationally muxed from the granted port's slices.
    - On c_ready=1 in the same cycle: m_ready[grant_idx]=1, m_rdata=c_rdata, then go to IDLE.
- Latency:
  - m_valid rising at cycle 0 gives c_valid at cycle 1.
  - Completion is the cycle c_ready is seen.
  - Minimum request-to-request spacing is 2 cycles: one IDLE cycle between grants.
- Handshake rules:
  - A master holds valid/addr/wdata/wstrb stable until its m_ready.
  - A master may not drop m_valid while granted. If it does, the arbiter ignores it and completes the transaction anyway.
  - m_ready is a single-cycle pulse. At most one bit is set per cycle.
- m_rdata:
  - Equals c_rdata in every cycle, unregistered.
  - Valid only in the m_ready cycle.
- Round-robin mode (ARB_MODE=0):
  - Search starts at rr pointer, increasing modulo N_PORTS.
  - The first requesting port wins.
  - On completion, rr pointer = grant_idx+1, wrapping N_PORTS-1 to 0.
- Fixed mode (ARB_MODE=1):
  - Lowest requesting index wins, unless a starvation override applies.
  - Each port requesting in IDLE but not granted increments its counter, saturating at STARVE_MAX.
  - The granted port's counter clears to 0.
  - Any port with counter==STARVE_MAX has priority over normal fixed priority. Among several such ports, lowest index wins.
  - Counters of non-requesting ports clear.
- Simultaneous events:
  - A new m_valid arriving during BUSY waits for the next IDLE arbitration.
  - c_ready with c_valid=0 is ignored.
- N_PORTS=1: always grants port 0, with the same IDLE/BUSY timing.
- Reset mid-transaction: everything returns to reset values immediately (asynchronous). The in-flight cache access is abandoned and no m_ready is issued. Masters must reissue.
- Controller accesses (address MSB set when CTRL_CACHE=1) are arbitrated identically. The arbiter does not decode the MSB.

Test Plan:
- Single port, read:
  - Stimulus: port 0 valid, addr=0x0000_0010, wstrb=0; cache ready 3 cycles after c_valid with c_rdata=0xDEADBEEF.
  - Required: c_valid at cycle 1; m_ready=2'b01 exactly one cycle; m_rdata=0xDEADBEEF on that cycle.
- Round-robin, both ports continuously valid, 4 transactions, ready after 1 cycle:
  - Required: grant order 0,1,0,1; each m_ready one-hot; IDLE cycle between grants.
- Fixed mode, STARVE_MAX=3, ports 0 and 1 continuously valid:
  - Required: port 0 wins 3 arbitrations, then port 1 is forced; pattern repeats 0,0,0,1.
- Write pass-through:
  - Stimulus: port 1 wstrb=4'b0101, wdata=0x11223344, addr=0x40.
  - Required: c_wstrb=4'b0101, c_wdata=0x11223344, c_addr=0x40 while c_valid; no m_ready until c_ready.
- Asynchronous reset asserted while BUSY (before c_ready):
  - Required: c_valid=0 and m_ready=0 within the reset cycle with no clock edge; after release, state IDLE and rr pointer=0.
- Late arrival:
  - Stimulus: port 1 valid rises while port 0 is BUSY.
  - Required: port 1 granted only after port 0's m_ready plus one IDLE cycle.

Source files
------------

// File: rtl/iob_cache_mp_arbiter.sv
// Multi-port front end for iob_cache: N native masters share one cache port.
// Round-robin or fixed-priority arbitration, with a starvation guard in fixed mode.
module iob_cache_mp_arbiter #(
    parameter int N_PORTS    = 2,
    parameter int FE_ADDR_W  = 32,
    parameter int FE_DATA_W  = 32,
    parameter int CTRL_CACHE = 0,
    parameter int ARB_MODE   = 0,
    parameter int STARVE_MAX = 15,
    parameter int FE_NBYTES  = FE_DATA_W / 8
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [N_PORTS-1:0]                       m_valid,
    input  logic [N_PORTS*(CTRL_CACHE+FE_ADDR_W)-1:0] m_addr,
    input  logic [N_PORTS*FE_DATA_W-1:0]             m_wdata,
    input  logic [N_PORTS*FE_NBYTES-1:0]             m_wstrb,
    output logic [FE_DATA_W-1:0]                     m_rdata,
    output logic [N_PORTS-1:0]                       m_ready,
    output logic                                     c_valid,
    output logic [CTRL_CACHE+FE_ADDR_W-1:0]          c_addr,
    output logic [FE_DATA_W-1:0]                     c_wdata,
    output logic [FE_NBYTES-1:0]                     c_wstrb,
    input  logic [FE_DATA_W-1:0]                     c_rdata,
    input  logic                                     c_ready,
    output logic [((N_PORTS > 1) ? $clog2(N_PORTS) : 1)-1:0] grant_idx
);

    localparam int AW = CTRL_CACHE + FE_ADDR_W;
    localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   arb_idx;
    logic [GW-1:0]   rr_ptr;
    logic            found;
    logic [3:0]      starve_cnt [N_PORTS];
    logic            any_req;
    logic            done;

    assign any_req   = |m_valid;
    assign done      = (state_q == BUSY) && c_ready;
    assign m_rdata   = c_rdata;
    assign grant_idx = grant_q;

    // Round-robin scans rr_ptr..N-1 first, then wraps to the lowest index.
    always_comb begin
        arb_idx = '0;
        found   = 1'b0;
        if (ARB_MODE == 0) begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (!found && m_valid[p] && (p >= int'(rr_ptr))) begin
                    found   = 1'b1;
                    arb_idx = GW'(p);
                end
            end
            for (int p = 0; p < N_PORTS; p++) begin
                if (!found && m_valid[p]) begin
                    found   = 1'b1;
                    arb_idx = GW'(p);
                end
            end
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (!found && m_valid[p] && (starve_cnt[p] == 4'(STARVE_MAX))) begin
                    found   = 1'b1;
                    arb_idx = GW'(p);
                end
            end
            for (int p = 0; p < N_PORTS; p++) begin
                if (!found && m_valid[p]) begin
                    found   = 1'b1;
                    arb_idx = GW'(p);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (c_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        c_valid = (state_q == BUSY);
        c_addr  = '0;
        c_wdata = '0;
        c_wstrb = '0;
        m_ready = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if ((state_q == BUSY) && (int'(grant_q) == k)) begin
                c_addr     = m_addr[k*AW +: AW];
                c_wdata    = m_wdata[k*FE_DATA_W +: FE_DATA_W];
                c_wstrb    = m_wstrb[k*FE_NBYTES +: FE_NBYTES];
                m_ready[k] = c_ready;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_ptr  <= '0;
            for (int k = 0; k < N_PORTS; k++) starve_cnt[k] <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && any_req) grant_q <= arb_idx;
            if (done) rr_ptr <= (int'(grant_q) == N_PORTS - 1) ? '0 : grant_q + GW'(1);
            // Losers that are still requesting age; the winner and idle ports restart.
            if ((ARB_MODE != 0) && (state_q == IDLE)) begin
                for (int k = 0; k < N_PORTS; k++) begin
                    if (m_valid[k] && (int'(arb_idx) != k)) begin
                        if (starve_cnt[k] < 4'(STARVE_MAX)) starve_cnt[k] <= starve_cnt[k] + 4'd1;
                    end else begin
                        starve_cnt[k] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_iob_cache_mp_arbiter.sv
// Bench for iob_cache_mp_arbiter: directed handshake steps, then randomized traffic
// against a transaction-level model, for one round-robin and one fixed-priority instance.
module tb_iob_cache_mp_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // index 0 drives the round-robin instance, index 1 the fixed-priority instance
    logic [1:0]  mv  [2];
    logic [63:0] ma  [2];
    logic [63:0] mw  [2];
    logic [7:0]  ms  [2];
    logic [31:0] crd [2];
    logic        cr  [2];

    logic [31:0] rr_rdata, fx_rdata;
    logic [1:0]  rr_mready, fx_mready;
    logic        rr_cvalid, fx_cvalid;
    logic [31:0] rr_caddr, fx_caddr, rr_cwdata, fx_cwdata;
    logic [3:0]  rr_cwstrb, fx_cwstrb;
    logic        rr_grant, fx_grant;

    logic [31:0] o_rdata  [2];
    logic [1:0]  o_mready [2];
    logic        o_cvalid [2];
    logic [31:0] o_caddr  [2];
    logic [31:0] o_cwdata [2];
    logic [3:0]  o_cwstrb [2];
    logic        o_grant  [2];

    always_comb begin
        o_rdata[0]  = rr_rdata;  o_rdata[1]  = fx_rdata;
        o_mready[0] = rr_mready; o_mready[1] = fx_mready;
        o_cvalid[0] = rr_cvalid; o_cvalid[1] = fx_cvalid;
        o_caddr[0]  = rr_caddr;  o_caddr[1]  = fx_caddr;
        o_cwdata[0] = rr_cwdata; o_cwdata[1] = fx_cwdata;
        o_cwstrb[0] = rr_cwstrb; o_cwstrb[1] = fx_cwstrb;
        o_grant[0]  = rr_grant;  o_grant[1]  = fx_grant;
    end

    iob_cache_mp_arbiter #(.N_PORTS(2), .FE_ADDR_W(32), .FE_DATA_W(32), .CTRL_CACHE(0),
                           .ARB_MODE(0), .STARVE_MAX(15)) dut_rr (
        .clk(clk), .reset(reset),
        .m_valid(mv[0]), .m_addr(ma[0]), .m_wdata(mw[0]), .m_wstrb(ms[0]),
        .m_rdata(rr_rdata), .m_ready(rr_mready),
        .c_valid(rr_cvalid), .c_addr(rr_caddr), .c_wdata(rr_cwdata), .c_wstrb(rr_cwstrb),
        .c_rdata(crd[0]), .c_ready(cr[0]), .grant_idx(rr_grant)
    );

    iob_cache_mp_arbiter #(.N_PORTS(2), .FE_ADDR_W(32), .FE_DATA_W(32), .CTRL_CACHE(0),
                           .ARB_MODE(1), .STARVE_MAX(3)) dut_fx (
        .clk(clk), .reset(reset),
        .m_valid(mv[1]), .m_addr(ma[1]), .m_wdata(mw[1]), .m_wstrb(ms[1]),
        .m_rdata(fx_rdata), .m_ready(fx_mready),
        .c_valid(fx_cvalid), .c_addr(fx_caddr), .c_wdata(fx_cwdata), .c_wstrb(fx_cwstrb),
        .c_rdata(crd[1]), .c_ready(cr[1]), .grant_idx(fx_grant)
    );

    int checks = 0;
    int errors = 0;
    int grant_log [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        for (int u = 0; u < 2; u++) begin
            mv[u] = '0;
            cr[u] = 1'b0;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        grant_log.delete();
    endtask

    // Transaction-level model: entered from IDLE right after reset, inputs idle.
    task automatic run_traffic(input int u, input int n_cycles, input int p_req, input int p_rdy);
        bit busy;
        bit prev_cv;
        int g, rr, w, p;
        int cnt [2];
        bit done [2];
        busy = 0; prev_cv = 0; g = 0; rr = 0;
        cnt = '{0, 0};
        done = '{0, 0};
        for (int i = 0; i < n_cycles; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (done[k] || !mv[u][k]) begin
                    if ($urandom_range(99) < p_req) begin
                        mv[u][k]          = 1'b1;
                        ma[u][k*32 +: 32] = $urandom;
                        mw[u][k*32 +: 32] = $urandom;
                        ms[u][k*4 +: 4]   = 4'($urandom);
                    end else begin
                        mv[u][k] = 1'b0;
                    end
                end
            end
            cr[u]  = busy ? ($urandom_range(99) < p_rdy) : ($urandom_range(3) == 0);
            crd[u] = $urandom;
            #1;
            chk("c_valid",   o_cvalid[u], busy);
            chk("grant_idx", o_grant[u],  g);
            chk("m_ready",   o_mready[u], (busy && cr[u]) ? (2'b01 << g) : 2'b00);
            chk("m_rdata",   o_rdata[u],  crd[u]);
            chk("c_addr",    o_caddr[u],  busy ? ma[u][g*32 +: 32] : 32'h0);
            chk("c_wdata",   o_cwdata[u], busy ? mw[u][g*32 +: 32] : 32'h0);
            chk("c_wstrb",   o_cwstrb[u], busy ? ms[u][g*4 +: 4] : 4'h0);
            if (o_cvalid[u] && !prev_cv) grant_log.push_back(int'(o_grant[u]));
            prev_cv = o_cvalid[u];

            done = '{0, 0};
            if (busy) begin
                if (cr[u]) begin
                    done[g] = 1;
                    rr      = (g + 1) % 2;
                    busy    = 0;
                end
            end else if (mv[u] != 2'b00) begin
                w = -1;
                if (u == 0) begin
                    for (int d = 0; d < 2; d++) begin
                        p = (rr + d) % 2;
                        if (w < 0 && mv[u][p]) w = p;
                    end
                end else begin
                    for (int k = 0; k < 2; k++) if (w < 0 && mv[u][k] && cnt[k] == 3) w = k;
                    for (int k = 0; k < 2; k++) if (w < 0 && mv[u][k]) w = k;
                end
                for (int k = 0; k < 2; k++)
                    cnt[k] = (k == w) ? 0 : (mv[u][k] ? ((cnt[k] < 3) ? cnt[k] + 1 : 3) : 0);
                g    = w;
                busy = 1;
            end else begin
                cnt = '{0, 0};
            end
            @(posedge clk);
            #1;
        end
        mv[u] = '0;
        cr[u] = 1'b0;
    endtask

    int exp_rr [4] = '{0, 1, 0, 1};
    int exp_fx [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            mv[u] = '0; ma[u] = '0; mw[u] = '0; ms[u] = '0; crd[u] = '0; cr[u] = 1'b0;
        end
        step();
        step();
        chk("rst_c_valid", o_cvalid[0], 1'b0);
        chk("rst_m_ready", o_mready[0], 2'b00);
        chk("rst_grant",   o_grant[0],  1'b0);
        chk("rst_c_addr",  o_caddr[0],  32'h0);
        chk("rst_c_wstrb", o_cwstrb[0], 4'h0);
        chk("rst_fx_c_valid", o_cvalid[1], 1'b0);
        reset = 1'b0;
        step();

        // single-port read, cache answers three cycles after c_valid
        mv[0] = 2'b01; ma[0] = 64'h0000_0000_0000_0010; ms[0] = 8'h00;
        #1;
        chk("rd_cycle0_c_valid", o_cvalid[0], 1'b0);
        step();
        chk("rd_cycle1_c_valid", o_cvalid[0], 1'b1);
        chk("rd_c_addr", o_caddr[0], 32'h10);
        chk("rd_grant",  o_grant[0], 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rd_wait_m_ready", o_mready[0], 2'b00);
            chk("rd_wait_c_valid", o_cvalid[0], 1'b1);
        end
        step();
        cr[0] = 1'b1; crd[0] = 32'hDEAD_BEEF;
        #1;
        chk("rd_m_ready", o_mready[0], 2'b01);
        chk("rd_m_rdata", o_rdata[0],  32'hDEAD_BEEF);
        step();
        cr[0] = 1'b0; mv[0] = 2'b00;
        #1;
        chk("rd_after_m_ready", o_mready[0], 2'b00);
        chk("rd_after_c_valid", o_cvalid[0], 1'b0);

        // write pass-through from port 1, port 0 slices hold unrelated values
        ma[0] = {32'h0000_0040, 32'hAAAA_0000};
        mw[0] = {32'h1122_3344, 32'h5566_7788};
        ms[0] = {4'b0101, 4'b1111};
        mv[0] = 2'b10;
        step();
        chk("wr_c_valid", o_cvalid[0], 1'b1);
        chk("wr_grant",   o_grant[0],  1'b1);
        chk("wr_c_addr",  o_caddr[0],  32'h40);
        chk("wr_c_wdata", o_cwdata[0], 32'h1122_3344);
        chk("wr_c_wstrb", o_cwstrb[0], 4'b0101);
        chk("wr_no_ready", o_mready[0], 2'b00);
        step();
        chk("wr_no_ready2", o_mready[0], 2'b00);
        chk("wr_c_wstrb2",  o_cwstrb[0], 4'b0101);
        cr[0] = 1'b1;
        #1;
        chk("wr_m_ready", o_mready[0], 2'b10);
        step();
        cr[0] = 1'b0; mv[0] = 2'b00;

        // late arrival: port 1 rises while port 0 is being served
        ma[0] = {32'h0000_0200, 32'h0000_0100};
        mv[0] = 2'b01;
        step();
        chk("late_grant0", o_grant[0], 1'b0);
        mv[0] = 2'b11;
        step();
        chk("late_still0", o_grant[0],  1'b0);
        chk("late_no_rdy", o_mready[0], 2'b00);
        cr[0] = 1'b1;
        #1;
        chk("late_rdy0", o_mready[0], 2'b01);
        step();
        cr[0] = 1'b0; mv[0] = 2'b10;
        #1;
        chk("late_idle_gap", o_cvalid[0], 1'b0);
        step();
        chk("late_c_valid1", o_cvalid[0], 1'b1);
        chk("late_grant1",   o_grant[0],  1'b1);
        chk("late_c_addr1",  o_caddr[0],  32'h200);
        cr[0] = 1'b1;
        #1;
        chk("late_rdy1", o_mready[0], 2'b10);
        step();
        cr[0] = 1'b0; mv[0] = 2'b00;

        // complete one port-0 access so the pointer moves, then reset mid-transaction
        mv[0] = 2'b01;
        step();
        cr[0] = 1'b1;
        step();
        cr[0] = 1'b0; mv[0] = 2'b00;
        step();
        mv[0] = 2'b01;
        step();
        chk("arst_busy", o_cvalid[0], 1'b1);
        cr[0] = 1'b1;
        reset = 1'b1;
        #1;
        chk("arst_c_valid", o_cvalid[0], 1'b0);
        chk("arst_m_ready", o_mready[0], 2'b00);
        chk("arst_c_addr",  o_caddr[0],  32'h0);
        mv[0] = 2'b00; cr[0] = 1'b0;
        step();
        reset = 1'b0;
        grant_log.delete();
        #1;
        chk("arst_idle", o_cvalid[0], 1'b0);

        // round-robin, both ports always requesting, cache ready at once
        run_traffic(0, 20, 100, 100);
        chk("rr_log_len", grant_log.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("rr_order", grant_log[i], exp_rr[i]);

        reset_pulse();
        run_traffic(0, 400, 40, 50);

        // fixed priority with STARVE_MAX=3, both ports always requesting
        reset_pulse();
        run_traffic(1, 40, 100, 100);
        chk("fx_log_len", grant_log.size() >= 8, 1'b1);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("fx_order", grant_log[i], exp_fx[i]);

        reset_pulse();
        run_traffic(1, 400, 60, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
